// File: rtl/arb_grant_bridge.sv
// ============================================================================
// arb_grant_bridge: clocked 4-phase endpoint for an async arbiter tree.
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb_grant_bridge #(
  parameter int INPUT_SIZE  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  localparam int IDX_W      = $clog2(INPUT_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arb_req,
  input  logic [INPUT_SIZE:0]   arb_grant,
  output logic                  arb_ack,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [IDX_W-1:0]      m_index,
  output logic                  err_grant,
  output logic [CNT_W-1:0]      served_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    OFFER = 3'd2,
    ACKHI = 3'd3,
    ACKLO = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [INPUT_SIZE:0]    grant_q, grant_d;
  logic                   arb_ack_q, arb_ack_d;
  logic                   m_valid_q, m_valid_d;
  logic [IDX_W-1:0]       m_index_q, m_index_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   req_s;
  logic                   grant_onehot;
  logic [IDX_W-1:0]       idx_enc;

  assign req_s        = sync_q[SYNC_STAGES-1];
  assign grant_onehot = $onehot(grant_q);

  always_comb begin
    idx_enc = '0;
    for (int i = 0; i <= INPUT_SIZE; i++) begin
      if (grant_q[i]) idx_enc = IDX_W'(i);
    end
  end

  // arb_grant is bundled data: it is sampled only after the synchronized
  // request is seen, never passed through the synchronizer itself.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    arb_ack_d = arb_ack_q;
    m_valid_d = m_valid_q;
    m_index_d = m_index_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          grant_d = arb_grant;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (grant_onehot) begin
          m_index_d = idx_enc;
          m_valid_d = 1'b1;
          state_d   = OFFER;
        end else begin
          err_d     = 1'b1;
          arb_ack_d = 1'b1;
          state_d   = ACKHI;
        end
      end
      OFFER: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          arb_ack_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d   = ACKHI;
        end
      end
      ACKHI: begin
        if (!req_s) begin
          arb_ack_d = 1'b0;
          state_d   = ACKLO;
        end
      end
      ACKLO:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      grant_q   <= '0;
      arb_ack_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_index_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], arb_req};
      grant_q   <= grant_d;
      arb_ack_q <= arb_ack_d;
      m_valid_q <= m_valid_d;
      m_index_q <= m_index_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign arb_ack    = arb_ack_q;
  assign m_valid    = m_valid_q;
  assign m_index    = m_index_q;
  assign err_grant  = err_q;
  assign served_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_arb_grant_bridge.sv
// ============================================================================
// tb_arb_grant_bridge: directed self-checking bench for arb_grant_bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_arb_grant_bridge;

  localparam int INPUT_SIZE  = 8;
  localparam int SYNC_STAGES = 2;
  localparam int IDX_W       = $clog2(INPUT_SIZE + 1);

  logic                clk = 1'b0;
  logic                rst_n;
  logic                arb_req;
  logic [INPUT_SIZE:0] arb_grant;
  logic                m_ready;

  logic                arb_ack,  arb_ack2;
  logic                m_valid,  m_valid2;
  logic [IDX_W-1:0]    m_index,  m_index2;
  logic                err_grant, err_grant2;
  logic [15:0]         served_cnt;
  logic [1:0]          served_cnt2;

  int errors  = 0;
  int checks  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  arb_grant_bridge #(.INPUT_SIZE(INPUT_SIZE), .SYNC_STAGES(SYNC_STAGES), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .arb_req(arb_req), .arb_grant(arb_grant),
    .arb_ack(arb_ack), .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index),
    .err_grant(err_grant), .served_cnt(served_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, for saturation.
  arb_grant_bridge #(.INPUT_SIZE(INPUT_SIZE), .SYNC_STAGES(SYNC_STAGES), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .arb_req(arb_req), .arb_grant(arb_grant),
    .arb_ack(arb_ack2), .m_valid(m_valid2), .m_ready(m_ready), .m_index(m_index2),
    .err_grant(err_grant2), .served_cnt(served_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Called just after an edge at which arb_req is already high and the
  // synchronizer is empty.
  task automatic handshake(input int exp_idx, input bit bad, input int hold);
    repeat (SYNC_STAGES + 1) tick;
    check("valid_before_latency", {31'd0, m_valid}, 32'd0);
    tick;
    if (bad) begin
      check("bad_err_pulse", {31'd0, err_grant}, 32'd1);
      check("bad_no_valid",  {31'd0, m_valid},   32'd0);
      check("bad_ack_high",  {31'd0, arb_ack},   32'd1);
      check("bad_cnt_hold",  {16'd0, served_cnt}, exp_cnt);
    end else begin
      check("valid_at_latency", {31'd0, m_valid}, 32'd1);
      check("index",            {28'd0, m_index}, exp_idx);
      check("ack_low_offer",    {31'd0, arb_ack}, 32'd0);
      for (int i = 0; i < hold; i++) begin
        m_ready = 1'b0;
        tick;
        check("bp_valid", {31'd0, m_valid}, 32'd1);
        check("bp_index", {28'd0, m_index}, exp_idx);
        check("bp_ack",   {31'd0, arb_ack}, 32'd0);
      end
      m_ready = 1'b1;
      tick;
      m_ready = 1'b0;
      exp_cnt++;
      check("accept_valid_drop", {31'd0, m_valid}, 32'd0);
      check("accept_ack_rise",   {31'd0, arb_ack}, 32'd1);
      check("served_cnt",        {16'd0, served_cnt}, exp_cnt);
      check("served_cnt_sat",    {30'd0, served_cnt2}, sat3(exp_cnt));
    end
    arb_req = 1'b0;
    tick;
    if (bad) check("err_one_cycle", {31'd0, err_grant}, 32'd0);
    check("ack_hold1", {31'd0, arb_ack}, 32'd1);
    tick;
    check("ack_hold2", {31'd0, arb_ack}, 32'd1);
    tick;
    check("ack_fall", {31'd0, arb_ack}, 32'd0);
    tick;
    check("ack_rtz", {31'd0, arb_ack}, 32'd0);
  endtask

  task automatic txn(input logic [INPUT_SIZE:0] g, input int exp_idx, input bit bad,
                     input int hold, input bit early_ready);
    arb_grant = g;
    m_ready   = early_ready;
    arb_req   = 1'b1;
    handshake(exp_idx, bad, hold);
  endtask

  initial begin
    logic [INPUT_SIZE:0] g;
    int b2b [5] = '{0, 8, 4, 1, 7};

    // T1: reset held with request pending
    rst_n = 1'b0; arb_req = 1'b1; arb_grant = 9'b000000001; m_ready = 1'b0;
    tick; tick;
    check("rst_ack",   {31'd0, arb_ack},    32'd0);
    check("rst_valid", {31'd0, m_valid},    32'd0);
    check("rst_index", {28'd0, m_index},    32'd0);
    check("rst_err",   {31'd0, err_grant},  32'd0);
    check("rst_cnt",   {16'd0, served_cnt}, 32'd0);
    rst_n = 1'b1;
    handshake(0, 1'b0, 0);

    // T2: single transaction, ready already high
    txn(9'b000001000, 3, 1'b0, 0, 1'b1);

    // T3: 10 cycles of backpressure
    txn(9'b000100000, 5, 1'b0, 10, 1'b0);

    // T4: malformed grants
    txn(9'b000010010, 0, 1'b1, 0, 1'b0);
    txn(9'b000000000, 0, 1'b1, 0, 1'b0);

    // T5: back-to-back
    for (int k = 0; k < 5; k++) begin
      g = '0;
      g[b2b[k]] = 1'b1;
      txn(g, b2b[k], 1'b0, k % 2, 1'b0);
    end
    check("b2b_total",     {16'd0, served_cnt},  32'd8);
    // T6: narrow counter pinned at all-ones
    check("sat_final",     {30'd0, served_cnt2}, 32'd3);

    // Reset mid-handshake, request still high afterwards
    arb_grant = 9'b100000000; arb_req = 1'b1;
    repeat (SYNC_STAGES + 2) tick;
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    check("pre_rst_ack", {31'd0, arb_ack}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ack", {31'd0, arb_ack},    32'd0);
    check("midrst_cnt", {16'd0, served_cnt}, 32'd0);
    tick;
    rst_n   = 1'b1;
    exp_cnt = 0;
    handshake(8, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
